// File: rtl/ece593w26_div.sv
// Sequential unsigned restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per cycle, with start/busy/done handshake and dz/ovf flags.
module ece593w26_div #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   n,
  input  logic [WIDTH-1:0]     d,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     r,
  output logic                 dz,
  output logic                 ovf,
  output logic [1:0]           state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: start is accepted only when busy=0 (IDLE); done pulses for one
  // cycle with q/r/dz/ovf valid, and busy stays high through that DONE cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH-1:0] acc_sh;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    acc_d   = acc_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    p_sh    = {p_q[WIDTH-1:0], acc_q[WIDTH-1]};
    acc_sh  = {acc_q[WIDTH-2:0], 1'b0};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (d == '0) begin
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
            q_d     = '1;
            r_d     = n[WIDTH-1:0];
            state_d = S_DONE;
          end else if (n[2*WIDTH-1:WIDTH] >= d) begin
            dz_d    = 1'b0;
            ovf_d   = 1'b1;
            q_d     = '1;
            r_d     = '0;
            state_d = S_DONE;
          end else begin
            p_d     = {1'b0, n[2*WIDTH-1:WIDTH]};
            acc_d   = n[WIDTH-1:0];
            dsr_d   = d;
            cnt_d   = CW'(WIDTH);
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (p_sh >= {1'b0, dsr_q}) begin
          p_sh      = p_sh - {1'b0, dsr_q};
          acc_sh[0] = 1'b1;
        end
        p_d   = p_sh;
        acc_d = acc_sh;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Flags are cleared here rather than at accept so visible outputs
          // only ever change on entry to DONE.
          q_d     = acc_sh;
          r_d     = p_sh[WIDTH-1:0];
          dz_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      acc_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign q         = q_q;
  assign r         = r_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule
